// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param: parametrised UART receiver (data width, parity, stop bits,
// oversampling) with valid/ack word handshake and parity/framing/overrun flags.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit
// around mid-bit instead of a single mid-bit sample.
module uart_rx_param #(
    parameter int CLKS_PER_TICK = 325,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [15:0]   TICK_LAST = 16'(CLKS_PER_TICK - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [SW-1:0] START_DEC = SW'(M);
`else
    localparam logic [SW-1:0] START_DEC = SW'(M - 1);
`endif
    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state_q, state_d;

    logic                 rx_meta_q, rxs_q, rxs_prev_q;
    logic [15:0]          tick_cnt_q;
    logic [SW-1:0]        samp_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q, ferr_q, done_q;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
    logic                 busy_c, frame_end;
    logic                 tick, start_edge, start_dec, bit_tick, bit_val;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign start_edge = (state_q == S_IDLE) && rxs_prev_q && !rxs_q;
    assign start_dec  = tick && (samp_cnt_q == START_DEC);
    assign bit_tick   = tick && (samp_cnt_q == SAMP_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    // Two previous tick samples; with the current one they form the vote window
    always_ff @(posedge clk) begin
        if (rst)       hist_q <= 2'b11;
        else if (tick) hist_q <= {hist_q[0], rxs_q};
    end
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
    assign bit_val = rxs_q;
`endif

    // Two-flop synchroniser plus edge-detect history, preset idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Tick and sample counters, realigned to the start edge of each frame
    always_ff @(posedge clk) begin
        if (rst || start_edge) begin
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
            if (state_q == S_START && start_dec)
                samp_cnt_q <= '0;
            else if (tick)
                samp_cnt_q <= (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + SW'(1);
        end
    end

    // Bit counter restarts whenever the FSM changes phase
    always_ff @(posedge clk) begin
        if (rst)                     bit_cnt_q <= '0;
        else if (state_d != state_q) bit_cnt_q <= '0;
        else if (bit_tick)           bit_cnt_q <= bit_cnt_q + 4'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_edge) state_d = S_START;
            S_START:  if (start_dec) state_d = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (bit_tick && bit_cnt_q == DATA_LAST)
                          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_tick) state_d = S_STOP;
            S_STOP:   if (bit_tick && bit_cnt_q == STOP_LAST) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and last-stop-sample strobe
    always_comb begin
        busy_c    = (state_q != S_IDLE);
        frame_end = (state_q == S_STOP) && bit_tick && (bit_cnt_q == STOP_LAST);
    end

    // Per-frame shift register and error accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= frame_end;
            case (state_q)
                S_START:  if (start_dec) begin
                              perr_q <= 1'b0;
                              ferr_q <= 1'b0;
                          end
                S_DATA:   if (bit_tick) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                S_PARITY: if (bit_tick) perr_q <= (((^shift_q) ^ bit_val) != PAR_ODD);
                S_STOP:   if (bit_tick && !bit_val) ferr_q <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Handshake: ack clears the held word; completion loads it or flags overrun
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
        if (data_ack && valid_q) begin
            valid_d = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done_q) begin
            if (!valid_q || data_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                pe_d    = perr_q;
                fe_d    = ferr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Output word and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = pe_q;
    assign frame_err   = fe_q;
    assign overrun_err = ovr_q;
    assign busy        = busy_c;
endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_param: three instances (8N1, 7E1, 8N2) at
// CLKS_PER_TICK=4, OVERSAMPLE=16, so one bit lasts 64 clocks.
module tb_uart_rx_param;
    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx8 = 1'b1, rx7 = 1'b1, rx2 = 1'b1;
    logic ack8 = 1'b0, ack7 = 1'b0, ack2 = 1'b0;
    logic [7:0] d8, d2;
    logic [6:0] d7;
    logic v8, pe8, fe8, ov8, b8;
    logic v7, pe7, fe7, ov7, b7;
    logic v2, pe2, fe2, ov2, b2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_TICK(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
        .clk(clk), .rst(rst), .rx(rx8), .data(d8), .data_valid(v8), .data_ack(ack8),
        .parity_err(pe8), .frame_err(fe8), .overrun_err(ov8), .busy(b8));

    uart_rx_param #(.CLKS_PER_TICK(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u7e1 (
        .clk(clk), .rst(rst), .rx(rx7), .data(d7), .data_valid(v7), .data_ack(ack7),
        .parity_err(pe7), .frame_err(fe7), .overrun_err(ov7), .busy(b7));

    uart_rx_param #(.CLKS_PER_TICK(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u8n2 (
        .clk(clk), .rst(rst), .rx(rx2), .data(d2), .data_valid(v2), .data_ack(ack2),
        .parity_err(pe2), .frame_err(fe2), .overrun_err(ov2), .busy(b2));

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rx8 = v;
            1:       rx7 = v;
            default: rx2 = v;
        endcase
    endtask

    // bits[0] is the start bit; frames are sent LSB first, called at a negedge
    task automatic send_frame(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            repeat (BIT_CLK) @(negedge clk);
        end
        drive(sel, 1'b1);
    endtask

    function automatic logic cur_valid(input int sel);
        case (sel)
            0:       return v8;
            1:       return v7;
            default: return v2;
        endcase
    endfunction

    task automatic wait_valid(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cur_valid(sel) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack(input int sel);
        case (sel)
            0:       ack8 = 1'b1;
            1:       ack7 = 1'b1;
            default: ack2 = 1'b1;
        endcase
        @(negedge clk);
        ack8 = 1'b0; ack7 = 1'b0; ack2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({d8, v8, pe8, fe8, ov8, b8} !== 13'h0) begin
            bad++; $display("FAIL reset_8n1 got=%h want=0", {d8, v8, pe8, fe8, ov8, b8});
        end
        total++;
        if ({d7, v7, pe7, fe7, ov7, b7} !== 12'h0) begin
            bad++; $display("FAIL reset_7e1 got=%h want=0", {d7, v7, pe7, fe7, ov7, b7});
        end
        total++;
        if ({d2, v2, pe2, fe2, ov2, b2} !== 13'h0) begin
            bad++; $display("FAIL reset_8n2 got=%h want=0", {d2, v2, pe2, fe2, ov2, b2});
        end
    endtask

    task automatic test_8n1();
        bit ok;
        send_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
        wait_valid(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL 8n1_valid got=0 want=1"); end
        total++;
        if (d8 !== 8'hA5) begin bad++; $display("FAIL 8n1_data got=%h want=a5", d8); end
        total++;
        if ({pe8, fe8, ov8} !== 3'b000) begin
            bad++; $display("FAIL 8n1_errs got=%b want=000", {pe8, fe8, ov8});
        end
        repeat (200) @(negedge clk);
        total++;
        if ({d8, v8} !== {8'hA5, 1'b1}) begin
            bad++; $display("FAIL 8n1_hold got=%h/%b want=a5/1", d8, v8);
        end
        pulse_ack(0);
        total++;
        if (v8 !== 1'b0) begin bad++; $display("FAIL 8n1_ack got=%b want=0", v8); end
    endtask

    task automatic test_parity();
        bit ok;
        send_frame(1, 16'({1'b1, 1'b0, 7'h07, 1'b0}), 10);
        wait_valid(1, ok);
        total++;
        if (!ok || d7 !== 7'h07 || pe7 !== 1'b1) begin
            bad++; $display("FAIL parity_bad got=%b/%h/%b want=1/07/1", ok, d7, pe7);
        end
        pulse_ack(1);
        total++;
        if ({v7, pe7} !== 2'b00) begin
            bad++; $display("FAIL parity_ack got=%b want=00", {v7, pe7});
        end
        send_frame(1, 16'({1'b1, 1'b1, 7'h07, 1'b0}), 10);
        wait_valid(1, ok);
        total++;
        if (!ok || d7 !== 7'h07 || pe7 !== 1'b0 || fe7 !== 1'b0) begin
            bad++; $display("FAIL parity_good got=%b/%h/%b/%b want=1/07/0/0", ok, d7, pe7, fe7);
        end
        pulse_ack(1);
    endtask

    task automatic test_stop2();
        bit ok;
        send_frame(2, 16'({1'b0, 1'b1, 8'h3C, 1'b0}), 11);
        wait_valid(2, ok);
        total++;
        if (!ok || d2 !== 8'h3C || fe2 !== 1'b1) begin
            bad++; $display("FAIL stop2_low got=%b/%h/%b want=1/3c/1", ok, d2, fe2);
        end
        pulse_ack(2);
        total++;
        if ({v2, fe2} !== 2'b00) begin
            bad++; $display("FAIL stop2_ack got=%b want=00", {v2, fe2});
        end
        send_frame(2, 16'({2'b00, 8'h00, 1'b0}), 11);
        wait_valid(2, ok);
        total++;
        if (!ok || d2 !== 8'h00 || fe2 !== 1'b1) begin
            bad++; $display("FAIL break got=%b/%h/%b want=1/00/1", ok, d2, fe2);
        end
        pulse_ack(2);
    endtask

    task automatic test_false_start();
        rx8 = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (b8 !== 1'b1) begin bad++; $display("FAIL false_busy got=%b want=1", b8); end
        repeat (10) @(negedge clk);
        rx8 = 1'b1;
        repeat (80) @(negedge clk);
        total++;
        if ({b8, v8} !== 2'b00) begin
            bad++; $display("FAIL false_idle got=%b want=00", {b8, v8});
        end
`ifdef UART_RX_MAJORITY_EN
        begin
            bit ok;
            logic [9:0] f;
            f = {1'b1, 8'h00, 1'b0};
            for (int i = 0; i < 10; i++) begin
                rx8 = f[i];
                if (i == 4) begin
                    repeat (30) @(negedge clk);
                    rx8 = 1'b1;
                    repeat (4) @(negedge clk);
                    rx8 = 1'b0;
                    repeat (30) @(negedge clk);
                end else begin
                    repeat (BIT_CLK) @(negedge clk);
                end
            end
            rx8 = 1'b1;
            wait_valid(0, ok);
            total++;
            if (!ok || d8 !== 8'h00 || fe8 !== 1'b0) begin
                bad++; $display("FAIL glitch got=%b/%h/%b want=1/00/0", ok, d8, fe8);
            end
            pulse_ack(0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit acked;
        send_frame(0, 16'({1'b1, 8'h11, 1'b0}), 10);
        send_frame(0, 16'({1'b1, 8'h22, 1'b0}), 10);
        @(negedge clk);
        total++;
        if ({d8, v8, ov8} !== {8'h11, 1'b1, 1'b1}) begin
            bad++; $display("FAIL overrun got=%h/%b/%b want=11/1/1", d8, v8, ov8);
        end
        pulse_ack(0);
        total++;
        if ({v8, pe8, fe8, ov8} !== 4'b0000) begin
            bad++; $display("FAIL overrun_ack got=%b want=0000", {v8, pe8, fe8, ov8});
        end
        send_frame(0, 16'({1'b1, 8'h44, 1'b0}), 10);
        wait_valid(0, ok);
        total++;
        if (!ok || d8 !== 8'h44) begin
            bad++; $display("FAIL prior_word got=%b/%h want=1/44", ok, d8);
        end
        acked = 1'b0;
        fork
            send_frame(0, 16'({1'b1, 8'h33, 1'b0}), 10);
            begin
                for (int i = 0; i < 100 && b8 !== 1'b1; i++) @(negedge clk);
                for (int i = 0; i < 800 && b8 === 1'b1; i++) @(negedge clk);
                if (b8 === 1'b0) begin
                    ack8 = 1'b1;
                    @(negedge clk);
                    ack8 = 1'b0;
                    acked = 1'b1;
                end
            end
        join
        total++;
        if (!acked || {d8, v8, ov8} !== {8'h33, 1'b1, 1'b0}) begin
            bad++; $display("FAIL ack_on_complete got=%b/%h/%b/%b want=1/33/1/0", acked, d8, v8, ov8);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        fork
            send_frame(0, 16'({1'b1, 8'hF0, 1'b0}), 10);
            begin
                repeat (BIT_CLK * 5 + 32) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                total++;
                if ({d8, v8, pe8, fe8, ov8, b8} !== 13'h0) begin
                    bad++; $display("FAIL midreset got=%h want=0", {d8, v8, pe8, fe8, ov8, b8});
                end
            end
        join
        @(negedge clk);
        total++;
        if ({b8, v8} !== 2'b00) begin
            bad++; $display("FAIL midreset_idle got=%b want=00", {b8, v8});
        end
        send_frame(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
        wait_valid(0, ok);
        total++;
        if (!ok || d8 !== 8'h5A || {pe8, fe8, ov8} !== 3'b000) begin
            bad++; $display("FAIL after_reset got=%b/%h/%b want=1/5a/000", ok, d8, {pe8, fe8, ov8});
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
